// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the
// sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // True when DIGITS decimal digits can hold 2^w-1
  function automatic bit bcd_fits(int w, int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p > ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the
// digit is 5 or more, wrapping within 4 bits.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle shift-add-3 binary-to-BCD converter,
// one input bit per clock, start/done handshake.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = cnt_width(W);
  localparam int BW = 4 * DIGITS;

  if (!bcd_fits(W, DIGITS)) begin : g_width_err
    $error("bin2bcd_seq: DIGITS too small for W");
  end

  state_t          state_q;
  logic [W-1:0]    shift_q;
  logic [BW-1:0]   scratch_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch_q[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CW'(W - 1);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct then shift in one step
          scratch_q <= {adj[BW-2:0], shift_q[W-1]};
          shift_q   <= {shift_q[W-2:0], 1'b0};
          if (cnt_q == '0) state_q <= DONE;
          else cnt_q <= cnt_q - CW'(1);
        end
        DONE: begin
          bcd_q   <= scratch_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Expected digits come from decimal arithmetic.
module tb_bin2bcd_seq;

  logic        sys_clk;
  logic        reset;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;

  int checks;
  int errors;

  bin2bcd_seq #(.W(8), .DIGITS(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Waits for done after an accept edge; n = edges seen.
  // busy_bad counts cycles before done where busy was low.
  task automatic wait_done(output int n, output int busy_bad);
    n = 0;
    busy_bad = 0;
    do begin
      @(posedge sys_clk);
      #1;
      n++;
      if (!done && !busy) busy_bad++;
    end while (!done && n < 30);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    bin   = 8'd0;
    #12;
    checks++;
    if ({busy, done, bcd} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h want 0 0 0000",
               busy, done, bcd);
    end
    @(negedge sys_clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({busy, done, bcd} !== 18'd0) begin
        errors++;
        $display("FAIL idle_after_reset: cyc %0d busy=%b done=%b bcd=%h want 0 0 0000",
                 i, busy, done, bcd);
      end
    end
  endtask

  task automatic test_single;
    int n, bb;
    start = 1'b1;
    bin   = 8'd225;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    bin   = 8'd0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(n, bb);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL single_latency: got %0d want 9", n);
    end
    checks++;
    if (bb !== 0) begin
      errors++;
      $display("FAIL single_busy: low for %0d cycles want 0", bb);
    end
    checks++;
    if (bcd !== 16'h0225 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_result: bcd=%h busy=%b want 0225 0", bcd, busy);
    end
    @(posedge sys_clk);
    #1;
    checks++;
    if (done !== 1'b0 || bcd !== 16'h0225) begin
      errors++;
      $display("FAIL single_pulse: done=%b bcd=%h want 0 0225", done, bcd);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [3];
    int n, bb;
    vals = '{8'd255, 8'd0, 8'd99};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      bin   = vals[i];
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept_%0d: done=%b busy=%b want 0 1", i, done, busy);
      end
      wait_done(n, bb);
      checks++;
      if (n !== 9 || bb !== 0) begin
        errors++;
        $display("FAIL b2b_latency_%0d: got %0d busy_low=%0d want 9 0", i, n, bb);
      end
      checks++;
      if (bcd !== ref_bcd(int'(vals[i]))) begin
        errors++;
        $display("FAIL b2b_result_%0d: got %h want %h", i, bcd, ref_bcd(int'(vals[i])));
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_start_held;
    int n, bb;
    start = 1'b1;
    bin   = 8'd128;
    @(posedge sys_clk);
    #1;
    bin = 8'd7;
    wait_done(n, bb);
    checks++;
    if (n !== 9 || bcd !== 16'h0128) begin
      errors++;
      $display("FAIL held_first: n=%0d bcd=%h want 9 0128", n, bcd);
    end
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held_reaccept: done=%b busy=%b want 0 1", done, busy);
    end
    wait_done(n, bb);
    checks++;
    if (n !== 9 || bcd !== 16'h0007) begin
      errors++;
      $display("FAIL held_second: n=%0d bcd=%h want 9 0007", n, bcd);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL held_extra_done: cyc %0d done=%b busy=%b want 0 0",
                 i, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    bin   = 8'd200;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, bcd} !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b done=%b bcd=%h want 0 0 0000",
               busy, done, bcd);
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({busy, done, bcd} !== 18'd0) begin
        errors++;
        $display("FAIL reset_mid_after: cyc %0d busy=%b done=%b bcd=%h want 0 0 0000",
                 i, busy, done, bcd);
      end
    end
  endtask

  task automatic test_exhaustive;
    int n, bb;
    for (int v = 0; v < 256; v++) begin
      start = 1'b1;
      bin   = 8'(v);
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      wait_done(n, bb);
      checks++;
      if (n !== 9 || done !== 1'b1 || bcd !== ref_bcd(v)) begin
        errors++;
        $display("FAIL exhaustive_%0d: n=%0d done=%b bcd=%h want 9 1 %h",
                 v, n, done, bcd, ref_bcd(v));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_start_held;
    test_reset_mid;
    test_exhaustive;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
